// File: rtl/rom_upload_pkg.sv
// Shared types and constants for the HPS upload read-back path.
package rom_upload_pkg;

   // Reader state machine.
   typedef enum logic [2:0] {
      ST_SYNC,
      ST_IDLE,
      ST_FETCH,
      ST_PREF,
      ST_DRAIN
   } state_t;

   // Byte returned for out-of-range or abandoned reads.
   localparam logic [7:0] FILL_BYTE = 8'hFF;

   // Word-tag width of the buffer entries; must match the SDRAM port address width.
   localparam int TAG_W = 23;

   // One buffered SDRAM word.
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [15:0]      data;
   } buf_entry_t;

endpackage

// File: rtl/upload_word_buf.sv
// Two-entry word buffer: the current word and one prefetched word.
module upload_word_buf
   import rom_upload_pkg::*;
(
   input  logic             clk_mem,
   input  logic             reset,
   input  logic [TAG_W-1:0] look_tag,
   output logic             hit_cur,
   output logic             hit_nxt,
   output logic [15:0]      cur_data,
   output logic [15:0]      nxt_data,
   input  logic             fill_cur,
   input  logic             fill_nxt,
   input  logic [TAG_W-1:0] fill_tag,
   input  logic [15:0]      fill_data,
   input  logic             promote,
   input  logic             inv_cur,
   input  logic             inv_nxt,
   input  logic             inv_all
);

   buf_entry_t cur_q;
   buf_entry_t nxt_q;

   assign hit_cur  = cur_q.valid && (cur_q.tag == look_tag);
   assign hit_nxt  = nxt_q.valid && (nxt_q.tag == look_tag);
   assign cur_data = cur_q.data;
   assign nxt_data = nxt_q.data;

   // Entry update: invalidate-all wins, a promote and a prefetch fill may land together.
   always_ff @(posedge clk_mem or posedge reset) begin
      if (reset) begin
         cur_q <= '0;
         nxt_q <= '0;
      end else if (inv_all) begin
         cur_q.valid <= 1'b0;
         nxt_q.valid <= 1'b0;
      end else begin
         if (fill_cur) begin
            cur_q <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
         end else if (promote) begin
            cur_q <= nxt_q;
         end else if (inv_cur) begin
            cur_q.valid <= 1'b0;
         end

         if (fill_nxt) begin
            nxt_q <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
         end else if (promote || inv_nxt) begin
            nxt_q.valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rom_upload_reader.sv
// Upload read-back engine: serves ioctl_rd bytes from an SDRAM toggle-handshake port.
module rom_upload_reader
   import rom_upload_pkg::*;
#(
   parameter int                ADDR_W  = 25,
   parameter int                PORT_AW = 23,
   parameter logic [ADDR_W-1:0] LIMIT   = 25'h1C320,
   parameter int                TIMEOUT = 255
) (
   input  logic               clk_mem,
   input  logic               reset,
   input  logic               ioctl_upload,
   input  logic               ioctl_rd,
   input  logic [ADDR_W-1:0]  ioctl_addr,
   output logic [7:0]         ioctl_din,
   output logic               ioctl_wait,
   output logic               port_req,
   input  logic               port_ack,
   output logic [PORT_AW-1:0] port_a,
   output logic [1:0]         port_ds,
   output logic               port_we,
   input  logic [15:0]        port_q,
   output logic               timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               pend;
   logic [ADDR_W-1:0]  dem_addr;

   logic               ack_match;
   logic               rd_ok;
   logic               in_range;
   logic               rd_miss;
   logic               rd_promote;
   logic               tmo;
   logic [PORT_AW-1:0] rd_tag;
   logic [PORT_AW-1:0] rd_tag_inc;
   logic [PORT_AW-1:0] ack_tag_inc;

   logic               hit_cur;
   logic               hit_nxt;
   logic [15:0]        cur_data;
   logic [15:0]        nxt_data;
   logic               fill_cur;
   logic               fill_nxt;
   logic               promote;
   logic               inv_cur;
   logic               inv_nxt;
   logic               inv_all;

   function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
      return hi ? w[15:8] : w[7:0];
   endfunction

   // A prefetch is only worth issuing if its word starts inside the uploadable region.
   function automatic logic pref_ok(input logic [PORT_AW-1:0] tag);
      return ADDR_W'({tag, 1'b0}) < LIMIT;
   endfunction

   assign port_ds     = 2'b11;
   assign port_we     = 1'b0;
   assign ack_match   = (port_ack == port_req);
   // A read arriving while one is already waiting (or mid-FETCH) is ignored.
   assign rd_ok       = ioctl_rd && ioctl_upload && !ioctl_wait &&
                        ((state == ST_IDLE) || (state == ST_PREF));
   assign in_range    = ioctl_addr < LIMIT;
   assign rd_tag      = ioctl_addr[PORT_AW:1];
   assign rd_tag_inc  = rd_tag + PORT_AW'(1);
   assign ack_tag_inc = port_a + PORT_AW'(1);
   assign rd_miss     = rd_ok && in_range && !hit_cur && !hit_nxt;
   assign rd_promote  = rd_ok && in_range && !hit_cur && hit_nxt;
   assign tmo         = (cnt == CNT_W'(TIMEOUT));

   upload_word_buf u_buf (
      .clk_mem   (clk_mem),
      .reset     (reset),
      .look_tag  (rd_tag),
      .hit_cur   (hit_cur),
      .hit_nxt   (hit_nxt),
      .cur_data  (cur_data),
      .nxt_data  (nxt_data),
      .fill_cur  (fill_cur),
      .fill_nxt  (fill_nxt),
      .fill_tag  (port_a),
      .fill_data (port_q),
      .promote   (promote),
      .inv_cur   (inv_cur),
      .inv_nxt   (inv_nxt),
      .inv_all   (inv_all)
   );

   // Buffer commands derived from the current state and this cycle's events.
   always_comb begin
      fill_cur = 1'b0;
      fill_nxt = 1'b0;
      inv_cur  = 1'b0;
      inv_nxt  = 1'b0;
      inv_all  = !ioctl_upload;
      promote  = rd_promote;
      case (state)
         ST_FETCH: if (ioctl_upload) begin
            if (ack_match)  fill_cur = 1'b1;
            else if (tmo)   inv_cur  = 1'b1;
         end
         ST_PREF: if (ioctl_upload) begin
            if (ack_match)  fill_nxt = 1'b1;
            else if (tmo)   inv_nxt  = 1'b1;
         end
         default: ;
      endcase
   end

   // Reader FSM with registered ioctl and port outputs.
   always_ff @(posedge clk_mem or posedge reset) begin
      if (reset) begin
         state       <= ST_SYNC;
         port_req    <= 1'b0;
         port_a      <= '0;
         ioctl_din   <= 8'h00;
         ioctl_wait  <= 1'b0;
         timeout_err <= 1'b0;
         cnt         <= '0;
         pend        <= 1'b0;
         dem_addr    <= '0;
      end else begin
         // Reads answered without touching the port.
         if (rd_ok) begin
            if (!in_range)    ioctl_din <= FILL_BYTE;
            else if (hit_cur) ioctl_din <= sel_byte(cur_data, ioctl_addr[0]);
            else if (hit_nxt) ioctl_din <= sel_byte(nxt_data, ioctl_addr[0]);
         end

         case (state)
            ST_SYNC: begin
               port_req <= port_ack;
               state    <= ST_IDLE;
            end

            ST_IDLE: begin
               if (rd_miss) begin
                  port_req   <= ~port_req;
                  port_a     <= rd_tag;
                  cnt        <= '0;
                  dem_addr   <= ioctl_addr;
                  ioctl_wait <= 1'b1;
                  state      <= ST_FETCH;
               end else if (rd_promote && pref_ok(rd_tag_inc)) begin
                  port_req <= ~port_req;
                  port_a   <= rd_tag_inc;
                  cnt      <= '0;
                  state    <= ST_PREF;
               end
            end

            ST_FETCH: begin
               if (!ioctl_upload) begin
                  ioctl_wait <= 1'b0;
                  pend       <= 1'b0;
                  state      <= ST_DRAIN;
               end else if (ack_match) begin
                  ioctl_din  <= sel_byte(port_q, dem_addr[0]);
                  ioctl_wait <= 1'b0;
                  if (pref_ok(ack_tag_inc)) begin
                     port_req <= ~port_req;
                     port_a   <= ack_tag_inc;
                     cnt      <= '0;
                     state    <= ST_PREF;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (tmo) begin
                  timeout_err <= 1'b1;
                  ioctl_din   <= FILL_BYTE;
                  ioctl_wait  <= 1'b0;
                  port_req    <= port_ack;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_PREF: begin
               if (!ioctl_upload) begin
                  ioctl_wait <= 1'b0;
                  pend       <= 1'b0;
                  state      <= ST_DRAIN;
               end else if (ack_match) begin
                  if (pend) begin
                     port_req <= ~port_req;
                     port_a   <= dem_addr[PORT_AW:1];
                     cnt      <= '0;
                     pend     <= 1'b0;
                     state    <= ST_FETCH;
                  end else if (rd_miss) begin
                     port_req   <= ~port_req;
                     port_a     <= rd_tag;
                     cnt        <= '0;
                     dem_addr   <= ioctl_addr;
                     ioctl_wait <= 1'b1;
                     state      <= ST_FETCH;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (tmo) begin
                  timeout_err <= 1'b1;
                  port_req    <= port_ack;
                  state       <= ST_IDLE;
                  if (pend) begin
                     ioctl_din  <= FILL_BYTE;
                     ioctl_wait <= 1'b0;
                     pend       <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (rd_miss) begin
                     pend       <= 1'b1;
                     dem_addr   <= ioctl_addr;
                     ioctl_wait <= 1'b1;
                  end
               end
            end

            ST_DRAIN: begin
               if (ack_match) state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_upload_reader.sv
// Bench for rom_upload_reader: SDRAM port responder plus a read scoreboard.
module tb_rom_upload_reader;

   localparam logic [24:0] LIMIT = 25'h1C320;

   logic        clk_mem = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_upload = 1'b0;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        port_req;
   logic        port_ack = 1'b1;
   logic [22:0] port_a;
   logic [1:0]  port_ds;
   logic        port_we;
   logic [15:0] port_q = '0;
   logic        timeout_err;

   int n_chk = 0;
   int n_bad = 0;

   logic [7:0]  sb_q[$];
   logic [22:0] req_log[$];

   bit          ack_en = 1'b0;
   int          ack_lat = 6;
   bit          busy = 1'b0;
   int          lat_left = 0;
   logic [22:0] busy_a = '0;

   rom_upload_reader dut (
      .clk_mem      (clk_mem),
      .reset        (reset),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .port_req     (port_req),
      .port_ack     (port_ack),
      .port_a       (port_a),
      .port_ds      (port_ds),
      .port_we      (port_we),
      .port_q       (port_q),
      .timeout_err  (timeout_err)
   );

   always #5 clk_mem = ~clk_mem;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_word(input logic [22:0] w);
      logic [22:0] p;
      p = w * 23'd40503;
      return p[15:0] ^ 16'h5AC3;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [24:0] a);
      logic [15:0] w;
      if (a >= LIMIT) return 8'hFF;
      w = mem_word(a[23:1]);
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   // SDRAM port model: acks ack_lat cycles after a toggle, checks port_a stays put.
   always @(negedge clk_mem) begin
      if (reset) begin
         busy = 1'b0;
      end else if (port_req != port_ack) begin
         if (!busy) begin
            busy     = 1'b1;
            busy_a   = port_a;
            lat_left = ack_lat;
            req_log.push_back(port_a);
         end else begin
            check_val("port_a_stable", port_a, busy_a);
         end
         if (ack_en) begin
            if (lat_left <= 1) begin
               port_q   = mem_word(port_a);
               port_ack = port_req;
               busy     = 1'b0;
            end else begin
               lat_left--;
            end
         end
      end else begin
         busy = 1'b0;
      end
   end

   task automatic do_read(input logic [24:0] a, input bit force_ff, output bit waited, output int lat);
      logic [7:0] e;
      @(negedge clk_mem); #1;
      ioctl_addr = a;
      ioctl_rd   = 1'b1;
      e = force_ff ? 8'hFF : exp_byte(a);
      sb_q.push_back(e);
      @(negedge clk_mem); #1;
      ioctl_rd = 1'b0;
      waited = 1'b0;
      lat    = 1;
      while (ioctl_wait && lat < 600) begin
         waited = 1'b1;
         @(negedge clk_mem); #1;
         lat++;
      end
      check_val($sformatf("rd_wait_budget_%0h", a), ioctl_wait, 1'b0);
      e = sb_q.pop_front();
      check_val($sformatf("rd_data_%0h", a), ioctl_din, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          w;
      int          l;
      int          n0;
      logic [7:0]  din_hold;

      // reset state, with the port ack sitting at 1
      repeat (3) @(negedge clk_mem);
      #1;
      check_val("rst_din", ioctl_din, 8'h00);
      check_val("rst_wait", ioctl_wait, 1'b0);
      check_val("rst_req", port_req, 1'b0);
      check_val("rst_a", port_a, 23'd0);
      check_val("rst_terr", timeout_err, 1'b0);
      check_val("port_ds", port_ds, 2'b11);
      check_val("port_we", port_we, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge clk_mem);
      #1;
      check_val("sync_req", port_req, 1'b1);
      check_val("sync_no_req", req_log.size(), 0);
      check_val("sync_wait", ioctl_wait, 1'b0);

      // sequential upload 0..7, gaps long enough for prefetches to land
      ack_en       = 1'b1;
      ack_lat      = 6;
      ioctl_upload = 1'b1;
      for (int a = 0; a < 8; a++) begin
         do_read(25'(a), 1'b0, w, l);
         check_val($sformatf("seq_wait_%0d", a), w, (a == 0));
         repeat (12) @(negedge clk_mem);
      end

      // out-of-range read and the last in-range byte
      n0 = req_log.size();
      do_read(25'h1C320, 1'b0, w, l);
      check_val("oor_wait", w, 1'b0);
      check_val("oor_lat", l, 1);
      repeat (3) @(negedge clk_mem);
      #1;
      check_val("oor_no_req", req_log.size(), n0);
      do_read(25'h1C31F, 1'b0, w, l);
      check_val("last_wait", w, 1'b1);
      repeat (15) @(negedge clk_mem);
      #1;
      check_val("last_no_pref", req_log.size(), n0 + 1);

      // ack never arrives
      ack_en = 1'b0;
      do_read(25'h0100, 1'b1, w, l);
      check_val("tmo_wait_seen", w, 1'b1);
      check_val("tmo_lat_ok", (l >= 255) && (l <= 262), 1'b1);
      check_val("tmo_err", timeout_err, 1'b1);
      check_val("tmo_resync", port_req == port_ack, 1'b1);
      ack_en = 1'b1;
      repeat (3) @(negedge clk_mem);

      // random read while a prefetch is in flight
      ack_lat = 20;
      do_read(25'h0200, 1'b0, w, l);
      n0 = req_log.size();
      check_val("pf_launched", req_log[n0-1], 23'h101);
      do_read(25'h4000, 1'b0, w, l);
      check_val("pf_dem_wait", w, 1'b1);
      check_val("pf_dem_lat", l >= 30, 1'b1);
      check_val("pf_order_pref", req_log[n0-1], 23'h101);
      check_val("pf_order_dem", req_log[n0], 23'h2000);
      repeat (40) @(negedge clk_mem);

      // upload drops while a demand read is outstanding
      ack_lat = 30;
      @(negedge clk_mem); #1;
      ioctl_addr = 25'h0800;
      ioctl_rd   = 1'b1;
      @(negedge clk_mem); #1;
      ioctl_rd = 1'b0;
      repeat (4) @(negedge clk_mem);
      #1;
      check_val("drop_fetch_wait", ioctl_wait, 1'b1);
      din_hold     = ioctl_din;
      n0           = req_log.size();
      ioctl_upload = 1'b0;
      repeat (3) @(negedge clk_mem);
      #1;
      check_val("drop_outstanding", port_req != port_ack, 1'b1);
      repeat (40) @(negedge clk_mem);
      #1;
      check_val("drop_din_kept", ioctl_din, din_hold);
      check_val("drop_drained", port_req == port_ack, 1'b1);
      check_val("drop_no_new_req", req_log.size(), n0);
      ioctl_upload = 1'b1;
      ack_lat      = 6;
      do_read(25'h4002, 1'b0, w, l);
      check_val("new_sess_miss", w, 1'b1);
      do_read(25'h4003, 1'b0, w, l);
      check_val("new_sess_hit", w, 1'b0);

      repeat (10) @(negedge clk_mem);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
